// File: rtl/basic_comp_pkg.sv
// Shared encodings for the basic computer: ALU codes, bus sources, opcodes,
// register-reference bit positions and the sequencer state type.
package basic_comp_pkg;

    localparam int DATA_W = 16;
    localparam int SC_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } fsm_t;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_LDA = 4'b0011;
    localparam logic [3:0] ALU_CMA = 4'b1001;
    localparam logic [3:0] ALU_CME = 4'b1010;
    localparam logic [3:0] ALU_CIR = 4'b1011;
    localparam logic [3:0] ALU_CIL = 4'b1100;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam int OP_AND = 0;
    localparam int OP_ADD = 1;
    localparam int OP_LDA = 2;
    localparam int OP_STA = 3;
    localparam int OP_BUN = 4;
    localparam int OP_BSA = 5;
    localparam int OP_ISZ = 6;
    localparam int OP_REG = 7;

    localparam int RR_CLA = 11;
    localparam int RR_CLE = 10;
    localparam int RR_CMA = 9;
    localparam int RR_CME = 8;
    localparam int RR_CIR = 7;
    localparam int RR_CIL = 6;
    localparam int RR_INC = 5;
    localparam int RR_SPA = 4;
    localparam int RR_SNA = 3;
    localparam int RR_SZA = 2;
    localparam int RR_SZE = 1;
    localparam int RR_HLT = 0;

endpackage

// File: rtl/timing_decoder.sv
// One-hot decode of the sequence counter (T0..T6) and the opcode (D0..D7).
module timing_decoder
    import basic_comp_pkg::*;
#(
    parameter int SC_W_P = SC_W
) (
    input  logic [SC_W_P-1:0] i_sc,
    input  logic [2:0]        i_op,
    output logic [6:0]        o_t,
    output logic [7:0]        o_d
);

    always_comb begin
        o_t = '0;
        o_d = '0;
        for (int unsigned k = 0; k < 7; k++)
            o_t[k] = (i_sc == SC_W_P'(k));
        for (int unsigned k = 0; k < 8; k++)
            o_d[k] = (i_op == 3'(k));
    end

endmodule

// File: rtl/basic_control_sequencer.sv
// Timing and control unit: sequence counter, instruction decode and the
// per-cycle bus/memory/register strobes for the 16-bit basic computer.
module basic_control_sequencer
    import basic_comp_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int SC_W_P   = SC_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DATA_W_P-1:0] ir_outdata,
    input  logic [DATA_W_P-1:0] ac_outdata,
    input  logic [DATA_W_P-1:0] dr_outdata,
    input  logic                e_outdata,
    output logic [SC_W_P-1:0]   sc_out,
    output logic [2:0]          bus_sel,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ar_ld,
    output logic                ar_inc,
    output logic                pc_ld,
    output logic                pc_inc,
    output logic                dr_ld,
    output logic                dr_inc,
    output logic                ac_ld,
    output logic                ac_clr,
    output logic                ac_inc,
    output logic                ir_ld,
    output logic                e_clr,
    output logic [3:0]          alu_code,
    output logic                halted
);

    fsm_t              r_fsm;
    logic [SC_W_P-1:0] r_sc;
    logic              r_i;
    logic [6:0]        w_t;
    logic [7:0]        w_d;
    logic              w_sc_clr;
    logic              w_halt_req;

    timing_decoder #(.SC_W_P(SC_W_P)) u_dec (
        .i_sc (r_sc),
        .i_op (ir_outdata[14:12]),
        .o_t  (w_t),
        .o_d  (w_d)
    );

    assign sc_out = r_sc;
    assign halted = (r_fsm == ST_HALT);

    // Gating on reset keeps the cycle in which reset is sampled strobe-free.
    always_comb begin
        bus_sel = BUS_NONE; alu_code = ALU_NOP;
        mem_read = 1'b0; mem_write = 1'b0;
        ar_ld = 1'b0; ar_inc = 1'b0; pc_ld = 1'b0; pc_inc = 1'b0;
        dr_ld = 1'b0; dr_inc = 1'b0; ac_ld = 1'b0; ac_clr = 1'b0;
        ac_inc = 1'b0; ir_ld = 1'b0; e_clr = 1'b0;
        w_sc_clr = 1'b0; w_halt_req = 1'b0;
        if (r_fsm == ST_RUN && !reset) begin
            if (w_t[0]) begin
                bus_sel = BUS_PC; ar_ld = 1'b1;
            end
            if (w_t[1]) begin
                bus_sel = BUS_MEM; mem_read = 1'b1; ir_ld = 1'b1; pc_inc = 1'b1;
            end
            if (w_t[2]) begin
                bus_sel = BUS_IR; ar_ld = 1'b1;
            end
            if (w_t[3]) begin
                if (!w_d[OP_REG]) begin
                    if (r_i) begin
                        bus_sel = BUS_MEM; mem_read = 1'b1; ar_ld = 1'b1;
                    end
                end else begin
                    w_sc_clr = 1'b1;
                    // Lowest-index bit has priority when several are set.
                    if (!r_i) begin
                        if      (ir_outdata[RR_HLT]) w_halt_req = 1'b1;
                        else if (ir_outdata[RR_SZE]) pc_inc = !e_outdata;
                        else if (ir_outdata[RR_SZA]) pc_inc = (ac_outdata == '0);
                        else if (ir_outdata[RR_SNA]) pc_inc = ac_outdata[DATA_W_P-1];
                        else if (ir_outdata[RR_SPA]) pc_inc = !ac_outdata[DATA_W_P-1];
                        else if (ir_outdata[RR_INC]) ac_inc = 1'b1;
                        else if (ir_outdata[RR_CIL]) begin ac_ld = 1'b1; alu_code = ALU_CIL; end
                        else if (ir_outdata[RR_CIR]) begin ac_ld = 1'b1; alu_code = ALU_CIR; end
                        else if (ir_outdata[RR_CME]) alu_code = ALU_CME;
                        else if (ir_outdata[RR_CMA]) begin ac_ld = 1'b1; alu_code = ALU_CMA; end
                        else if (ir_outdata[RR_CLE]) e_clr = 1'b1;
                        else if (ir_outdata[RR_CLA]) ac_clr = 1'b1;
                    end
                end
            end
            if (w_t[4]) begin
                if (w_d[OP_AND] || w_d[OP_ADD] || w_d[OP_LDA] || w_d[OP_ISZ]) begin
                    bus_sel = BUS_MEM; mem_read = 1'b1; dr_ld = 1'b1;
                end
                if (w_d[OP_STA]) begin
                    bus_sel = BUS_AC; mem_write = 1'b1; w_sc_clr = 1'b1;
                end
                if (w_d[OP_BUN]) begin
                    bus_sel = BUS_AR; pc_ld = 1'b1; w_sc_clr = 1'b1;
                end
                if (w_d[OP_BSA]) begin
                    bus_sel = BUS_PC; mem_write = 1'b1; ar_inc = 1'b1;
                end
            end
            if (w_t[5]) begin
                if (w_d[OP_AND] || w_d[OP_ADD] || w_d[OP_LDA]) begin
                    ac_ld = 1'b1; w_sc_clr = 1'b1;
                    alu_code = w_d[OP_AND] ? ALU_AND : (w_d[OP_ADD] ? ALU_ADD : ALU_LDA);
                end
                if (w_d[OP_BSA]) begin
                    bus_sel = BUS_AR; pc_ld = 1'b1; w_sc_clr = 1'b1;
                end
                if (w_d[OP_ISZ]) dr_inc = 1'b1;
            end
            if (w_t[6] && w_d[OP_ISZ]) begin
                bus_sel = BUS_DR; mem_write = 1'b1; w_sc_clr = 1'b1;
                pc_inc = (dr_outdata == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm <= ST_IDLE;
            r_sc  <= '0;
            r_i   <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (start) r_fsm <= ST_RUN;
                    r_sc <= '0;
                end
                ST_RUN: begin
                    if (w_t[2]) r_i <= ir_outdata[DATA_W_P-1];
                    if (w_halt_req) begin
                        r_fsm <= ST_HALT;
                        r_sc  <= '0;
                    end else if (w_sc_clr) begin
                        r_sc <= '0;
                    end else begin
                        r_sc <= r_sc + 1'b1;
                    end
                end
                default: r_fsm <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_basic_control_sequencer.sv
// Directed bench for basic_control_sequencer: expected per-cycle outputs are
// queued as each step is driven and popped for comparison mid-cycle.
module tb_basic_control_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, e_outdata;
    logic [15:0] ir_outdata, ac_outdata, dr_outdata;
    logic [2:0]  sc_out, bus_sel;
    logic        mem_read, mem_write, ar_ld, ar_inc, pc_ld, pc_inc;
    logic        dr_ld, dr_inc, ac_ld, ac_clr, ac_inc, ir_ld, e_clr, halted;
    logic [3:0]  alu_code;

    always #5 clk = ~clk;

    basic_control_sequencer #(.DATA_W_P(16), .SC_W_P(3)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ir_outdata(ir_outdata), .ac_outdata(ac_outdata),
        .dr_outdata(dr_outdata), .e_outdata(e_outdata),
        .sc_out(sc_out), .bus_sel(bus_sel),
        .mem_read(mem_read), .mem_write(mem_write),
        .ar_ld(ar_ld), .ar_inc(ar_inc), .pc_ld(pc_ld), .pc_inc(pc_inc),
        .dr_ld(dr_ld), .dr_inc(dr_inc), .ac_ld(ac_ld), .ac_clr(ac_clr),
        .ac_inc(ac_inc), .ir_ld(ir_ld), .e_clr(e_clr),
        .alu_code(alu_code), .halted(halted)
    );

    localparam logic [12:0] MR = 13'h1000, MW = 13'h0800, ARLD = 13'h0400;
    localparam logic [12:0] ARINC = 13'h0200, PCLD = 13'h0100, PCINC = 13'h0080;
    localparam logic [12:0] DRLD = 13'h0040, DRINC = 13'h0020, ACLD = 13'h0010;
    localparam logic [12:0] ACCLR = 13'h0008, ACINC = 13'h0004, IRLD = 13'h0002;
    localparam logic [12:0] ECLR = 13'h0001;

    // Observation word: {sc, bus_sel, strobes, alu_code, halted}.
    logic [23:0] obs;
    assign obs = {sc_out, bus_sel,
                  mem_read, mem_write, ar_ld, ar_inc, pc_ld, pc_inc,
                  dr_ld, dr_inc, ac_ld, ac_clr, ac_inc, ir_ld, e_clr,
                  alu_code, halted};

    typedef struct {
        string       tag;
        logic [23:0] exp;
    } item_t;

    item_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic step(input string tag, input logic [2:0] sc, input logic [2:0] bus,
                        input logic [12:0] stb, input logic [3:0] alu, input logic hlt);
        item_t it;
        it.tag = tag;
        it.exp = {sc, bus, stb, alu, hlt};
        sb.push_back(it);
        @(negedge clk);
        it = sb.pop_front();
        n_cmp++;
        assert (obs === it.exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", it.tag, obs, it.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string n);
        step({n, " T0"}, 3'd0, 3'd2, ARLD, 4'd0, 1'b0);
        step({n, " T1"}, 3'd1, 3'd7, MR | IRLD | PCINC, 4'd0, 1'b0);
        step({n, " T2"}, 3'd2, 3'd5, ARLD, 4'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; e_outdata = 1'b0;
        ir_outdata = '0; ac_outdata = '0; dr_outdata = '0;
        @(posedge clk);
        #1;
        step("reset", 3'd0, 3'd0, '0, 4'd0, 1'b0);
        reset = 1'b0;
        step("idle", 3'd0, 3'd0, '0, 4'd0, 1'b0);
        start = 1'b1;
        step("idle_start", 3'd0, 3'd0, '0, 4'd0, 1'b0);
        start = 1'b0;

        ir_outdata = 16'h1005; dr_outdata = 16'h0003; ac_outdata = 16'h0004;
        fetch("add");
        step("add T3", 3'd3, 3'd0, '0, 4'd0, 1'b0);
        step("add T4", 3'd4, 3'd7, MR | DRLD, 4'd0, 1'b0);
        step("add T5", 3'd5, 3'd0, ACLD, 4'b0010, 1'b0);

        ir_outdata = 16'h8100;
        fetch("and_ind");
        step("and_ind T3", 3'd3, 3'd7, MR | ARLD, 4'd0, 1'b0);
        step("and_ind T4", 3'd4, 3'd7, MR | DRLD, 4'd0, 1'b0);
        step("and_ind T5", 3'd5, 3'd0, ACLD, 4'b0001, 1'b0);

        ir_outdata = 16'h6020;
        fetch("isz_wrap");
        step("isz_wrap T3", 3'd3, 3'd0, '0, 4'd0, 1'b0);
        dr_outdata = 16'hFFFF;
        step("isz_wrap T4", 3'd4, 3'd7, MR | DRLD, 4'd0, 1'b0);
        step("isz_wrap T5", 3'd5, 3'd0, DRINC, 4'd0, 1'b0);
        dr_outdata = 16'h0000;
        step("isz_wrap T6", 3'd6, 3'd3, MW | PCINC, 4'd0, 1'b0);

        fetch("isz_noskip");
        step("isz_noskip T3", 3'd3, 3'd0, '0, 4'd0, 1'b0);
        dr_outdata = 16'h0001;
        step("isz_noskip T4", 3'd4, 3'd7, MR | DRLD, 4'd0, 1'b0);
        step("isz_noskip T5", 3'd5, 3'd0, DRINC, 4'd0, 1'b0);
        dr_outdata = 16'h0002;
        step("isz_noskip T6", 3'd6, 3'd3, MW, 4'd0, 1'b0);

        ir_outdata = 16'h3010;
        fetch("sta");
        step("sta T3", 3'd3, 3'd0, '0, 4'd0, 1'b0);
        step("sta T4", 3'd4, 3'd4, MW, 4'd0, 1'b0);

        ir_outdata = 16'h4010;
        fetch("bun");
        step("bun T3", 3'd3, 3'd0, '0, 4'd0, 1'b0);
        step("bun T4", 3'd4, 3'd1, PCLD, 4'd0, 1'b0);

        ir_outdata = 16'h5010;
        fetch("bsa");
        step("bsa T3", 3'd3, 3'd0, '0, 4'd0, 1'b0);
        step("bsa T4", 3'd4, 3'd2, MW | ARINC, 4'd0, 1'b0);
        step("bsa T5", 3'd5, 3'd1, PCLD, 4'd0, 1'b0);

        ir_outdata = 16'h7080;
        fetch("cir");
        step("cir T3", 3'd3, 3'd0, ACLD, 4'b1011, 1'b0);

        ir_outdata = 16'h7010; ac_outdata = 16'h8000;
        fetch("spa_neg");
        step("spa_neg T3", 3'd3, 3'd0, '0, 4'd0, 1'b0);

        ir_outdata = 16'h7004; ac_outdata = 16'h0000;
        fetch("sza_zero");
        step("sza_zero T3", 3'd3, 3'd0, PCINC, 4'd0, 1'b0);

        ir_outdata = 16'h7300;
        fetch("cma_cme");
        step("cma_cme T3", 3'd3, 3'd0, '0, 4'b1010, 1'b0);

        ir_outdata = 16'h7800;
        fetch("cla");
        step("cla T3", 3'd3, 3'd0, ACCLR, 4'd0, 1'b0);

        ir_outdata = 16'h7400;
        fetch("cle");
        step("cle T3", 3'd3, 3'd0, ECLR, 4'd0, 1'b0);

        ir_outdata = 16'hF400;
        fetch("io");
        step("io T3", 3'd3, 3'd0, '0, 4'd0, 1'b0);

        ir_outdata = 16'h6020;
        fetch("isz_rst");
        step("isz_rst T3", 3'd3, 3'd0, '0, 4'd0, 1'b0);
        dr_outdata = 16'h0005;
        step("isz_rst T4", 3'd4, 3'd7, MR | DRLD, 4'd0, 1'b0);
        reset = 1'b1;
        step("isz_rst T5 reset", 3'd5, 3'd0, '0, 4'd0, 1'b0);
        reset = 1'b0;
        step("after_reset idle", 3'd0, 3'd0, '0, 4'd0, 1'b0);

        start = 1'b1;
        step("hlt start", 3'd0, 3'd0, '0, 4'd0, 1'b0);
        start = 1'b0;
        ir_outdata = 16'h7001;
        fetch("hlt");
        step("hlt T3", 3'd3, 3'd0, '0, 4'd0, 1'b0);
        step("halted", 3'd0, 3'd0, '0, 4'd0, 1'b1);
        start = 1'b1;
        step("halted start1", 3'd0, 3'd0, '0, 4'd0, 1'b1);
        step("halted start2", 3'd0, 3'd0, '0, 4'd0, 1'b1);
        start = 1'b0;
        reset = 1'b1;
        step("halted reset", 3'd0, 3'd0, '0, 4'd0, 1'b1);
        reset = 1'b0;
        step("idle after halt", 3'd0, 3'd0, '0, 4'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/basic_control_sequencer.md
Name: basic_control_sequencer

Overview:
- Timing and control unit for the 16-bit basic computer. It owns the sequence counter (T0..T6), decodes the IR opcode (D0..D7) and the I bit, and issues per-cycle register, memory and bus strobes.
- It drives `alu_code` into the ALU and reads AC/DR/E status for skip and ISZ decisions.
- It sits between the register file, the common bus and the ALU. It is the only source of `alu_code` and of every load/inc/clr strobe.

Parameters:
- DATA_W, 16, datapath width (AC, DR, IR).
- SC_W, 3, sequence counter width (T0..T7 encodable; T6 is the maximum used).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- start  in  1  level; in IDLE, a high sample moves to RUN.
- ir_outdata  in  16  IR contents: [15]=I, [14:12]=opcode, [11:0]=address/register-ref bits.
- ac_outdata  in  16  AC contents (used for SPA/SNA/SZA).
- dr_outdata  in  16  DR contents (used for the ISZ zero test).
- e_outdata  in  1  E flip-flop (used for SZE).
- sc_out  out  3  current T index.
- bus_sel  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 memory.
- mem_read / mem_write  out  1 each.
- ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld, ac_clr, ac_inc, ir_ld, e_clr  out  1 each: register strobes.
- alu_code  out  4  0000 nop, 0001 AND, 0010 ADD, 0011 pass DR, 1001 CMA, 1010 CME, 1011 CIR, 1100 CIL.
- halted  out  1  high in HALT.

Behaviour:
- Top FSM states: IDLE, RUN, HALT. Registered state: `fsm`, `sc`, and the latched I bit `i_q` (captured at T2).
- Reset: `fsm`=IDLE, `sc`=0, `i_q`=0, `halted`=0. Every strobe is 0, `bus_sel`=0, `alu_code`=0000.
- Reset asserted mid-instruction overrides everything on that edge. No strobe is issued in the reset cycle.
- IDLE: all strobes 0. If `start`=1, go to RUN with `sc`=0. The first fetch strobes appear in the next cycle.
- HALT: all strobes 0, `halted`=1. Only reset exits HALT; `start` is ignored.
- Strobes are combinational from (`fsm`, `sc`, `ir_outdata`, `i_q`, status inputs) and are valid only in RUN. The register file acts on them at the next edge.
- `sc` increments each RUN cycle. It clears to 0 on any cycle marked "SC<-0". It never exceeds 6.
- Fetch/decode:
  - T0: `bus_sel`=PC, `ar_ld`.
  - T1: `bus_sel`=mem, `mem_read`, `ir_ld`, `pc_inc`.
  - T2: `bus_sel`=IR, `ar_ld`; `i_q` <= IR[15].
- T3, opcode != 7:
  - If `i_q`=1: `bus_sel`=mem, `mem_read`, `ar_ld`.
  - If `i_q`=0: no strobes.
- Memory-reference instructions (T4 onward):
  - AND/ADD/LDA (D0/D1/D2): T4 `bus_sel`=mem, `mem_read`, `dr_ld`. T5 `ac_ld`, `alu_code`=0001/0010/0011, SC<-0.
  - STA: T4 `bus_sel`=AC, `mem_write`, SC<-0.
  - BUN: T4 `bus_sel`=AR, `pc_ld`, SC<-0.
  - BSA: T4 `bus_sel`=PC, `mem_write`, `ar_inc`. T5 `bus_sel`=AR, `pc_ld`, SC<-0.
  - ISZ:
    - T4 `bus_sel`=mem, `mem_read`, `dr_ld`.
    - T5 `dr_inc`.
    - T6 `bus_sel`=DR, `mem_write`; `pc_inc` iff `dr_outdata`==0; SC<-0.
    - Wrap case: DR 16'hFFFF at T4 becomes 0 at T6 and the skip is taken.
- Register-reference instructions (opcode 7, `i_q`=0), T3, SC<-0. The single active bit of IR[11:0] selects the action:
  - CLA: `ac_clr`. CLE: `e_clr`.
  - CMA: `ac_ld`, `alu_code` 1001. CME: `alu_code` 1010.
  - CIR: `ac_ld`, `alu_code` 1011. CIL: `ac_ld`, `alu_code` 1100.
  - INC: `ac_inc`.
  - SPA: `pc_inc` if AC[15]=0. SNA: `pc_inc` if AC[15]=1. SZA: `pc_inc` if AC==0. SZE: `pc_inc` if E=0.
  - HLT: `fsm`<=HALT.
  - Multiple bits set: the lowest-index bit wins. No bit set: NOP.
- I/O (opcode 7, `i_q`=1): NOP at T3, SC<-0.
- Latency per instruction:
  - STA/BUN: 5 cycles.
  - AND/ADD/LDA/BSA: 6 cycles.
  - ISZ: 7 cycles.
  - Register-ref: 4 cycles.
  - Indirect addressing adds no cycles (T3 is always consumed).

Decomposition:
- Shared package `basic_comp_pkg`:
  - `alu_code` constants (shared with the ALU).
  - `bus_sel` encodings.
  - opcode constants D0..D7.
  - register-ref bit indices (CLA=11 .. HLT=0).
  - FSM state enum.
- One sub-module, `timing_decoder`: maps `sc` to one-hot T0..T6 and IR[14:12] to one-hot D0..D7. Purely combinational.

Test Plan:
- Reset mid-ISZ at T5 -> next cycle `sc`=0, `fsm`=IDLE, all strobes 0, `halted`=0.
- start=1, IR=16'h1005 (ADD direct), DR=16'h0003, AC=16'h0004 -> sequence T0..T5. At T5 `ac_ld`=1 and `alu_code`=0010. Returns to T0 with `sc`=0; total 6 cycles.
- IR=16'h8100 (AND indirect) -> T3 shows `mem_read`=1, `ar_ld`=1, `bus_sel`=7. T5 `alu_code`=0001.
- IR=16'h6020 (ISZ), DR=16'hFFFF at T4 -> T6 shows `mem_write`=1, `bus_sel`=3, `pc_inc`=1. Same test with DR=16'h0001 -> `pc_inc`=0.
- IR=16'h7080 (CIR) -> T3 `ac_ld`=1, `alu_code`=1011, next `sc`=0. IR=16'h7010 (SPA) with AC=16'h8000 -> `pc_inc`=0.
- IR=16'h7001 (HLT) -> `halted`=1 from the next cycle. `start` pulses are then ignored; only reset returns to IDLE.
